// File: rtl/fir_stereo_sched.sv
// Stereo FIR with one shared MAC: round-robin L/R accept, TAPS_N-cycle MAC per sample, saturated output.
// Accept-to-out_valid latency TAPS_N+2 cycles; inputs are not ready while busy, and the result is held until out_ready.
module fir_stereo_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int TAPS_N     = 16,
  parameter int ACC_WIDTH  = 36,
  parameter int COEF_SHIFT = 8,
  parameter int COEF_RESET = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          l_valid,
  output logic                          l_ready,
  input  logic signed [DATA_WIDTH-1:0]  l_data,
  input  logic                          r_valid,
  output logic                          r_ready,
  input  logic signed [DATA_WIDTH-1:0]  r_data,
  input  logic                          cfg_we,
  input  logic [$clog2(TAPS_N)-1:0]     cfg_addr,
  input  logic signed [DATA_WIDTH-1:0]  cfg_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [DATA_WIDTH-1:0]  out_data,
  output logic                          out_chan,
  output logic                          busy
);

  localparam int AW = $clog2(TAPS_N);
  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, MAC, OUT} state_t;

  state_t                       state, state_nxt;
  logic                         last_grant;
  logic                         grant_r;
  logic                         accept;
  logic                         addr_ok;
  logic                         cfg_apply;
  logic                         mac_last;
  logic                         chan_q;
  logic signed [DATA_WIDTH-1:0] sample_q;
  logic signed [DATA_WIDTH-1:0] dline [2][TAPS_N];
  logic signed [DATA_WIDTH-1:0] coeff [TAPS_N];
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic signed [ACC_WIDTH-1:0]  acc_shr;
  logic signed [PW-1:0]         prod;
  logic [AW-1:0]                tap_k;
  logic                         sat_hi, sat_lo;
  logic signed [DATA_WIDTH-1:0] sat_val;

  // last_grant = 1 means right was served last, so a tie goes to left.
  assign grant_r   = r_valid && (!l_valid || !last_grant);
  assign l_ready   = !rst && (state == IDLE) && !cfg_we && l_valid && !grant_r;
  assign r_ready   = !rst && (state == IDLE) && !cfg_we && grant_r;
  assign accept    = (l_valid && l_ready) || (r_valid && r_ready);
  assign cfg_apply = (state == IDLE) && cfg_we && addr_ok;
  assign mac_last  = (tap_k == AW'(TAPS_N - 1));

  generate
    if ((1 << AW) == TAPS_N) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_part
      assign addr_ok = ({1'b0, cfg_addr} < (AW+1)'(TAPS_N));
    end
  endgenerate

  always_comb begin
    prod    = dline[chan_q][tap_k] * coeff[tap_k];
    acc_sum = acc + $signed({{(ACC_WIDTH-PW){prod[PW-1]}}, prod});
    acc_shr = acc_sum >>> COEF_SHIFT;
    // Out of range when the bits above the output sign bit disagree with the accumulator sign.
    sat_hi  = !acc_shr[ACC_WIDTH-1] && (|acc_shr[ACC_WIDTH-2:DATA_WIDTH-1]);
    sat_lo  = acc_shr[ACC_WIDTH-1] && !(&acc_shr[ACC_WIDTH-2:DATA_WIDTH-1]);
    if (sat_hi)
      sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (sat_lo)
      sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      sat_val = acc_shr[DATA_WIDTH-1:0];
  end

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: state_nxt = MAC;
      MAC:  if (mac_last) state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      chan_q     <= 1'b0;
      sample_q   <= '0;
      acc        <= '0;
      tap_k      <= '0;
      out_data   <= '0;
      out_chan   <= 1'b0;
      for (int k = 0; k < TAPS_N; k++) begin
        dline[0][k] <= '0;
        dline[1][k] <= '0;
        coeff[k]    <= DATA_WIDTH'(COEF_RESET);
      end
    end else begin
      state <= state_nxt;
      if (cfg_apply)
        coeff[cfg_addr] <= cfg_data;
      if (accept) begin
        sample_q   <= grant_r ? r_data : l_data;
        chan_q     <= grant_r;
        last_grant <= grant_r;
      end
      case (state)
        LOAD: begin
          for (int k = TAPS_N - 1; k > 0; k--)
            dline[chan_q][k] <= dline[chan_q][k-1];
          dline[chan_q][0] <= sample_q;
          acc   <= '0;
          tap_k <= '0;
        end
        MAC: begin
          acc   <= acc_sum;
          tap_k <= tap_k + 1'b1;
          if (mac_last) begin
            out_data <= sat_val;
            out_chan <= chan_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_stereo_sched.sv
// Randomised and directed bench for fir_stereo_sched against a per-sample FIR reference model.
module tb_fir_stereo_sched;

  localparam int DW   = 16;
  localparam int TAPS = 16;
  localparam int LAT  = TAPS + 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 l_valid, l_ready, r_valid, r_ready;
  logic signed [DW-1:0] l_data, r_data;
  logic                 cfg_we;
  logic [3:0]           cfg_addr;
  logic signed [DW-1:0] cfg_data;
  logic                 out_valid, out_ready, out_chan, busy;
  logic signed [DW-1:0] out_data;

  always #5 clk = ~clk;

  fir_stereo_sched #(
    .DATA_WIDTH(DW), .TAPS_N(TAPS), .ACC_WIDTH(36), .COEF_SHIFT(8), .COEF_RESET(16)
  ) dut (
    .clk(clk), .rst(rst),
    .l_valid(l_valid), .l_ready(l_ready), .l_data(l_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .busy(busy)
  );

  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc   = 0;
  int     lq[$];
  int     rq[$];
  int     log_d[$];
  int     log_c[$];
  bit     gate = 0, rnd_cfg = 0, rnd_ready = 0;
  logic   ready_level = 1'b1;

  // Reference model state: per-channel history, coefficient bank, one outstanding result.
  longint hist [2][TAPS];
  longint coef [TAPS];
  bit     m_free, m_pend, m_last;
  int     m_due, m_exp_d, m_exp_c;

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int fir(input int ch);
    longint a = 0;
    for (int k = 0; k < TAPS; k++) a += hist[ch][k] * coef[k];
    a = a >>> 8;
    if (a > 32767) a = 32767;
    if (a < -32768) a = -32768;
    return int'(a);
  endfunction

  function automatic int logd(input int i);
    return (i < log_d.size()) ? log_d[i] : -99999;
  endfunction

  function automatic int logc(input int i);
    return (i < log_c.size()) ? log_c[i] : -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      hist[0][k] = 0;
      hist[1][k] = 0;
      coef[k]    = 16;
    end
    m_free = 1;
    m_pend = 0;
    m_last = 1;
  endtask

  task automatic model_cycle();
    bit exp_ov, g, exp_l, exp_r;
    if (rst) begin
      chk("l_ready_in_reset", l_ready, 0);
      chk("r_ready_in_reset", r_ready, 0);
      model_reset();
      return;
    end
    exp_ov = m_pend && (cyc >= m_due);
    chk("out_valid", out_valid, int'(exp_ov));
    chk("busy", busy, int'(!m_free));
    if (exp_ov) begin
      chk("out_data", $signed(out_data), m_exp_d);
      chk("out_chan", out_chan, m_exp_c);
    end
    if (l_valid && r_valid) g = !m_last;
    else                    g = r_valid;
    exp_l = m_free && !cfg_we && l_valid && !g;
    exp_r = m_free && !cfg_we && r_valid && g;
    chk("l_ready", l_ready, int'(exp_l));
    chk("r_ready", r_ready, int'(exp_r));
    if (m_free && cfg_we) begin
      if (int'(cfg_addr) < TAPS) coef[cfg_addr] = longint'(cfg_data);
    end else if (exp_l || exp_r) begin
      for (int k = TAPS - 1; k > 0; k--) hist[g][k] = hist[g][k-1];
      hist[g][0] = g ? longint'(r_data) : longint'(l_data);
      if (g) void'(rq.pop_front());
      else   void'(lq.pop_front());
      m_last  = g;
      m_exp_d = fir(int'(g));
      m_exp_c = int'(g);
      m_pend  = 1;
      m_due   = cyc + LAT;
      m_free  = 0;
    end
    if (exp_ov && out_ready) begin
      log_d.push_back(int'($signed(out_data)));
      log_c.push_back(int'(out_chan));
      m_pend = 0;
      m_free = 1;
    end
  endtask

  task automatic drive();
    l_valid = (lq.size() != 0) && (!gate || $urandom_range(0, 3) != 0);
    l_data  = (lq.size() != 0) ? DW'(lq[0]) : '0;
    r_valid = (rq.size() != 0) && (!gate || $urandom_range(0, 3) != 0);
    r_data  = (rq.size() != 0) ? DW'(rq[0]) : '0;
    if (rnd_cfg) begin
      cfg_we   = ($urandom_range(0, 11) == 0);
      cfg_addr = 4'($urandom_range(0, TAPS - 1));
      cfg_data = DW'($urandom);
    end
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_level;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic run(input int max);
    int n = 0;
    drive();
    while ((lq.size() != 0 || rq.size() != 0 || m_pend || !m_free) && n < max) begin
      step();
      n++;
    end
    chk("drained_in_budget", int'(n < max), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    drive();
  endtask

  task automatic cfg(input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_addr = 4'(addr);
    cfg_data = DW'(data);
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic wait_accept();
    int n = 0;
    while (m_free && n < 50) begin
      step();
      n++;
    end
    chk("accept_seen", int'(n < 50), 1);
  endtask

  task automatic impulse_check(input string tag);
    int base = log_d.size();
    lq.push_back(256);
    repeat (19) lq.push_back(0);
    run(2000);
    chk({tag, "_count"}, log_d.size() - base, 20);
    for (int i = 0; i < 16; i++) chk({tag, "_tap"}, logd(base + i), 16);
    chk({tag, "_tail"}, logd(base + 16), 0);
    chk({tag, "_chan"}, logc(base), 0);
  endtask

  initial begin
    int base;
    rst = 1'b1; l_valid = 0; r_valid = 0; l_data = '0; r_data = '0;
    cfg_we = 0; cfg_addr = '0; cfg_data = '0; out_ready = 1'b1;
    model_reset();
    do_reset();
    chk("reset_out_data", $signed(out_data), 0);
    chk("reset_out_chan", out_chan, 0);
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", out_valid, 0);

    impulse_check("impulse");

    do_reset();
    base = log_d.size();
    repeat (6) begin
      lq.push_back(1000);
      rq.push_back(-1000);
    end
    run(2000);
    chk("tie_chan0", logc(base), 0);
    chk("tie_chan1", logc(base + 1), 1);
    chk("tie_chan2", logc(base + 2), 0);
    chk("tie_chan3", logc(base + 3), 1);
    chk("tie_left1", logd(base), 62);
    chk("tie_right1", logd(base + 1), -63);
    chk("tie_left2", logd(base + 2), 125);
    chk("tie_right2", logd(base + 3), -125);

    cfg(0, 256);
    for (int i = 1; i < TAPS; i++) cfg(i, 0);
    base = log_d.size();
    lq.push_back(1234);
    lq.push_back(-5);
    run(2000);
    chk("pass_a", logd(base), 1234);
    chk("pass_b", logd(base + 1), -5);
    lq.push_back(777);
    drive();
    wait_accept();
    repeat (4) step();
    cfg(0, 0);
    run(2000);
    lq.push_back(42);
    run(2000);
    chk("busy_cfg_a", logd(base + 2), 777);
    chk("busy_cfg_b", logd(base + 3), 42);

    for (int i = 0; i < TAPS; i++) cfg(i, 32767);
    repeat (17) lq.push_back(32767);
    run(3000);
    chk("sat_pos", logd(log_d.size() - 1), 32767);
    repeat (17) lq.push_back(-32768);
    run(3000);
    chk("sat_neg", logd(log_d.size() - 1), -32768);

    do_reset();
    base = log_d.size();
    ready_level = 1'b0;
    lq.push_back(100);
    rq.push_back(55);
    drive();
    repeat (45) step();
    chk("bp_no_output", log_d.size() - base, 0);
    chk("bp_valid_held", out_valid, 1);
    chk("bp_right_waiting", rq.size(), 1);
    ready_level = 1'b1;
    run(2000);
    chk("bp_count", log_d.size() - base, 2);
    chk("bp_left", logd(base), 6);
    chk("bp_right", logd(base + 1), 3);
    chk("bp_right_chan", logc(base + 1), 1);

    do_reset();
    base = log_d.size();
    lq.push_back(256);
    drive();
    wait_accept();
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_no_output", log_d.size() - base, 0);
    impulse_check("reimpulse");

    do_reset();
    gate = 1; rnd_cfg = 1; rnd_ready = 1;
    repeat (40) begin
      lq.push_back(int'($urandom_range(0, 65535)) - 32768);
      rq.push_back(int'($urandom_range(0, 65535)) - 32768);
    end
    base = log_d.size();
    run(20000);
    gate = 0; rnd_cfg = 0; rnd_ready = 0; cfg_we = 1'b0;
    chk("rand_count", log_d.size() - base, 80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
